// File: rtl/mdio_1ton_if.sv
// mdio_1ton_if: MDIO master-side and per-PHY signal bundle for the 1-to-N fan-out.
// The slave modport is the fan-out block; the master modport is the MDIO master together with the PHYs.
interface mdio_1ton_if #(parameter int NUM_PHYS = 2);
    logic mdio_mdc;
    logic mdio_o;
    logic mdio_t;
    logic mdio_i;
    logic [NUM_PHYS-1:0] phy_mdc;
    logic [NUM_PHYS-1:0] phy_mdio_o;
    logic [NUM_PHYS-1:0] phy_mdio_t;
    logic [NUM_PHYS-1:0] phy_mdio_i;
    modport master (
        output mdio_mdc, mdio_o, mdio_t, phy_mdio_i,
        input  mdio_i, phy_mdc, phy_mdio_o, phy_mdio_t
    );
    modport slave (
        input  mdio_mdc, mdio_o, mdio_t, phy_mdio_i,
        output mdio_i, phy_mdc, phy_mdio_o, phy_mdio_t
    );
endinterface

// File: rtl/mdio_1ton.sv
// mdio_1ton: tracks MDIO frames and routes a single master to one of NUM_PHYS PHY ports by PHYAD.
// Define MDIO_1TON_BCAST_EN to keep all ports connected for frames addressed to BCAST_ADDR.
module mdio_1ton #(
    parameter int         NUM_PHYS      = 2,
    parameter logic [4:0] PHY_ADDR_BASE = 5'd0,
    parameter logic [4:0] BCAST_ADDR    = 5'd31
) (
    input  logic       clk,
    input  logic       resetn,
    mdio_1ton_if.slave bus,
    output logic       busy,
    output logic       sel_valid
);
    typedef enum logic [2:0] {PRE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;
    state_t state, state_n;
    logic [2:0] mdc_q;
    logic [1:0] o_q, t_q;
    logic [4:0] ones, ones_n, full;
    logic [3:0] cnt, cnt_n, last, addr, addr_n;
    logic [5:0] diff;
    logic [NUM_PHYS-1:0] mask, mask_n;
    logic pre_ok, pre_ok_n, op_hi, op_hi_n, sel_valid_n, rise, smp, hit, bcast;
`ifndef MDIO_1TON_BCAST_EN
    logic unused_bcast;
    assign unused_bcast = ^BCAST_ADDR;
`endif
    // mask: all ones = broadcast, one-hot = selected port, zero = everything released
    assign bus.phy_mdc    = {NUM_PHYS{bus.mdio_mdc}};
    assign bus.phy_mdio_o = ~mask | {NUM_PHYS{bus.mdio_o}};
    assign bus.phy_mdio_t = ~mask | {NUM_PHYS{bus.mdio_t}};
    assign bus.mdio_i     = &(bus.phy_mdio_i | ~mask);
    assign rise = mdc_q[1] & ~mdc_q[2];
    assign smp  = t_q[1] ? bus.mdio_i : o_q[1];
    assign busy = state != PRE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdc_q     <= '0;
            o_q       <= '1;
            t_q       <= '1;
            state     <= PRE;
            ones      <= '0;
            pre_ok    <= 1'b0;
            cnt       <= '0;
            op_hi     <= 1'b0;
            addr      <= '0;
            mask      <= '1;
            sel_valid <= 1'b0;
        end else begin
            mdc_q     <= {mdc_q[1:0], bus.mdio_mdc};
            o_q       <= {o_q[0], bus.mdio_o};
            t_q       <= {t_q[0], bus.mdio_t};
            state     <= state_n;
            ones      <= ones_n;
            pre_ok    <= pre_ok_n;
            cnt       <= cnt_n;
            op_hi     <= op_hi_n;
            addr      <= addr_n;
            mask      <= mask_n;
            sel_valid <= sel_valid_n;
        end
    end
    always_comb begin
        state_n     = state;
        ones_n      = ones;
        pre_ok_n    = pre_ok;
        cnt_n       = cnt;
        op_hi_n     = op_hi;
        addr_n      = addr;
        mask_n      = mask;
        sel_valid_n = sel_valid;
        full        = {addr, smp};
        diff        = {1'b0, full} - {1'b0, PHY_ADDR_BASE};
        hit         = diff < 6'(NUM_PHYS);
`ifdef MDIO_1TON_BCAST_EN
        bcast       = full == BCAST_ADDR;
`else
        bcast       = 1'b0;
`endif
        last        = state == DATA ? 4'd15 : (state == OP || state == TA) ? 4'd1 : 4'd4;
        if (rise) begin
            case (state)
                // the counter saturates at 31, so pre_ok marks the 32nd consecutive one
                PRE: begin
                    ones_n   = smp ? (ones == 5'd31 ? ones : ones + 5'd1) : '0;
                    pre_ok_n = smp && (pre_ok || ones == 5'd31);
                    state_n  = (!smp && pre_ok) ? ST : PRE;
                end
                ST: begin
                    state_n = smp ? OP : PRE;
                    cnt_n   = '0;
                end
                default: begin
                    cnt_n   = cnt == last ? '0 : cnt + 4'd1;
                    op_hi_n = smp;
                    addr_n  = {addr[2:0], smp};
                    if (cnt == last) begin
                        case (state)
                            OP:    state_n = (op_hi ^ smp) ? PHYAD : PRE;
                            PHYAD: begin
                                state_n     = REGAD;
                                mask_n      = bcast ? '1 : hit ? NUM_PHYS'(1) << diff[2:0] : '0;
                                sel_valid_n = !bcast && hit;
                            end
                            REGAD: state_n = TA;
                            TA:    state_n = DATA;
                            default: begin
                                state_n     = PRE;
                                mask_n      = '1;
                                sel_valid_n = 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/mdio_1ton.md
MDIO_1TON -- requirements
Module: mdio_1ton

Interface
REQ-001 Parameter NUM_PHYS, default 2, number of downstream PHY ports; legal range 1..8.
REQ-002 Parameter PHY_ADDR_BASE, default 5'd0, PHYAD of port 0; port k answers PHY_ADDR_BASE+k; PHY_ADDR_BASE+NUM_PHYS-1 SHALL be <= 31.
REQ-003 Parameter BCAST_ADDR, default 5'd31, broadcast PHYAD; used only when MDIO_1TON_BCAST_EN is defined.
REQ-004 clk  in  1  system clock; frequency SHALL be >= 10x MDC.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 mdio_mdc  in  1  MDC from the MDIO master.
REQ-007 mdio_o  in  1  master data out.
REQ-008 mdio_t  in  1  master tristate enable, 1 = released.
REQ-009 mdio_i  out  1  data returned to the master.
REQ-010 phy_mdc  out  NUM_PHYS  per-port MDC.
REQ-011 phy_mdio_o  out  NUM_PHYS  per-port data out.
REQ-012 phy_mdio_t  out  NUM_PHYS  per-port tristate, 1 = released.
REQ-013 phy_mdio_i  in  NUM_PHYS  per-port data in.
REQ-014 busy  out  1  high while a frame is being tracked (any state other than IDLE/PRE).
REQ-015 sel_valid  out  1  high while one port is selected for the current frame.

Function
REQ-016 phy_mdc SHALL equal {NUM_PHYS{mdio_mdc}} combinationally, with no gating.
REQ-017 mdio_mdc, mdio_o and mdio_t SHALL pass through a 2-flop synchronizer; MDC rising edges SHALL be detected in clk, and each rising edge SHALL sample the synchronized mdio_o (master driving) or the AND/selected mdio_i (master released).
REQ-018 The FSM SHALL have states PRE, ST, OP, PHYAD, REGAD, TA, DATA, with a 5-bit preamble-ones counter saturating at 31 and a 4-bit bit counter.
REQ-019 PRE: count consecutive sampled ones; at >= 32 ones, a sampled 0 SHALL move to ST; a 0 with fewer than 32 ones SHALL clear the counter.
REQ-020 ST: a sampled 1 SHALL move to OP; a sampled 0 SHALL return to PRE.
REQ-021 OP: capture 2 bits; 2'b10 = read, 2'b01 = write; any other value SHALL return to PRE. Otherwise move to PHYAD.
REQ-022 PHYAD: shift 5 bits MSB first; on the 5th bit, decode the select and move to REGAD.
REQ-023 Select decode: if PHYAD-PHY_ADDR_BASE < NUM_PHYS, sel_idx = the difference and sel_valid = 1; otherwise the frame is unmatched and sel_valid = 0.
REQ-024 REGAD takes 5 bits, TA takes 2 bits, DATA takes 16 bits; after the 16th DATA bit the FSM SHALL return to PRE with the ones counter at 0.
REQ-025 Routing in PRE, ST, OP, PHYAD: every port SHALL get phy_mdio_o = mdio_o and phy_mdio_t = mdio_t, and mdio_i SHALL be the AND of all phy_mdio_i.
REQ-026 Routing from REGAD to the end of the frame, matched: the selected port SHALL carry mdio_o/mdio_t; every other port SHALL get phy_mdio_o = 1 and phy_mdio_t = 1; mdio_i = phy_mdio_i[sel_idx].
REQ-027 Routing from REGAD to the end of the frame, unmatched: all ports SHALL be released (o = 1, t = 1) and mdio_i = 1.
REQ-028 Routing selects SHALL be registered; the path from phy_mdio_i to mdio_i SHALL be combinational through the mux.
REQ-029 sel_valid SHALL clear when the FSM returns to PRE.
REQ-030 A new preamble or frame arriving mid-frame SHALL be ignored until the 16 DATA bits complete; there is no timeout.

Reset
REQ-031 On resetn low, asynchronously: FSM to PRE, counters to 0, sel_valid = 0, busy = 0, routing to the broadcast mode of REQ-025.
REQ-032 A reset asserted mid-frame SHALL abort the frame; after release the block SHALL require a full 32-bit preamble again.

Configuration
REQ-033 Macro MDIO_1TON_BCAST_EN defined: PHYAD == BCAST_ADDR SHALL keep broadcast routing (REQ-025) through DATA, with sel_valid = 0 and busy = 1.
REQ-034 Macro MDIO_1TON_BCAST_EN undefined: BCAST_ADDR SHALL be ignored and the address treated per REQ-023.

Verification
REQ-035 NUM_PHYS = 4, base 8: write to PHYAD 10, data 16'hA5A5 -> only port 2 toggles during REGAD..DATA; ports 0, 1 and 3 hold o = 1, t = 1; sel_valid = 1.
REQ-036 Read from PHYAD 9 with port 1 returning 16'h1234 and the other ports driving 0 -> master samples 16'h1234.
REQ-037 Read from PHYAD 3 (unmatched) -> mdio_i = 1 for all 16 data bits and sel_valid = 0.
REQ-038 Preamble of 31 ones followed by ST -> frame not tracked, busy stays 0; repeat with 32 ones -> tracked.
REQ-039 resetn pulsed low at DATA bit 7 -> busy = 0 and broadcast routing within 1 clk; the next frame decodes correctly.
REQ-040 With MDIO_1TON_BCAST_EN, write to PHYAD 31 -> all 4 ports carry the data through DATA; without the macro -> all ports released.
